// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle MIPS main control unit:
//   - state_t      : 4-bit FSM state encoding
//   - OP_*         : opcode field constants
//   - EN_*         : En_UC operation-class codes (shared with ALU control)
//   - SRCB_*/PCSRC_*: ALUSrcB and PCSrc mux select codes
//   - ctrl_out_t   : bundle of every control output
// Optional feature macro: MULTICYCLE_JUMP_EN (adds the j opcode / JUMP state).
// ----------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMM_EX  = 4'd9,
`ifdef MULTICYCLE_JUMP_EN
        S_JUMP    = 4'd11,
`endif
        S_IMM_WB  = 4'd10
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    // En_UC operation classes; 110 and 111 are reserved.
    localparam logic [2:0] EN_FUNCT = 3'b000;
    localparam logic [2:0] EN_ADD   = 3'b001;
    localparam logic [2:0] EN_SUB   = 3'b010;
    localparam logic [2:0] EN_AND   = 3'b011;
    localparam logic [2:0] EN_OR    = 3'b100;
    localparam logic [2:0] EN_SLT   = 3'b101;

    // ALU B input select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] en_uc;
        logic       illegal;
    } ctrl_out_t;

    // True for every opcode DECODE knows how to dispatch.
    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return 1'b1;
`ifdef MULTICYCLE_JUMP_EN
            OP_J:                              return 1'b1;
`endif
            default:                           return 1'b0;
        endcase
    endfunction

    // Operation class for the immediate-ALU instructions.
    function automatic logic [2:0] imm_en_uc(input logic [5:0] op);
        case (op)
            OP_ANDI: return EN_AND;
            OP_ORI:  return EN_OR;
            OP_SLTI: return EN_SLT;
            default: return EN_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// ----------------------------------------------------------------------------
// ctrl_out_decode
// Combinational decode of the control FSM state into every datapath control.
// Moore decode, except: En_UC in IMM_EX follows Op, illegal flags an
// unsupported Op in DECODE, and FETCH gates IRWrite/PCWrite with mem_ready.
// Ports:
//   state     in  current FSM state
//   Op        in  opcode field from the IR
//   mem_ready in  memory access completes this cycle
//   out       out decoded control bundle (ungated by reset)
// Optional feature macro: MULTICYCLE_JUMP_EN.
// ----------------------------------------------------------------------------
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output ctrl_out_t  out
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        out = '0;
        case (state)
            S_FETCH: begin
                out.mem_read  = 1'b1;
                out.alu_src_b = SRCB_FOUR;
                out.en_uc     = EN_ADD;
                // IR and PC advance only once the fetch actually returns data.
                out.ir_write  = mem_ready;
                out.pc_write  = mem_ready;
            end
            S_DECODE: begin
                out.alu_src_b = SRCB_IMM_SH;
                out.en_uc     = EN_ADD;
                out.illegal   = ~op_supported(Op);
            end
            S_MEM_ADR: begin
                out.alu_src_a = 1'b1;
                out.alu_src_b = SRCB_IMM;
                out.en_uc     = EN_ADD;
            end
            S_MEM_RD: begin
                out.i_or_d   = 1'b1;
                out.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                out.reg_write  = 1'b1;
                out.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                out.i_or_d    = 1'b1;
                out.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                out.alu_src_a = 1'b1;
                out.en_uc     = EN_FUNCT;
            end
            S_ALU_WB: begin
                out.reg_dst   = 1'b1;
                out.reg_write = 1'b1;
            end
            S_BRANCH: begin
                out.alu_src_a = 1'b1;
                out.en_uc     = EN_SUB;
                out.branch    = 1'b1;
                out.pc_src    = PCSRC_ALUOUT;
            end
            S_IMM_EX: begin
                out.alu_src_a = 1'b1;
                out.alu_src_b = SRCB_IMM;
                out.en_uc     = imm_en_uc(Op);
            end
            S_IMM_WB: begin
                out.reg_write = 1'b1;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP: begin
                out.pc_write = 1'b1;
                out.pc_src   = PCSRC_JUMP;
            end
`endif
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of the multicycle MIPS datapath. Holds the state register
// and next-state logic; output decode lives in ctrl_out_decode. All outputs
// are forced low while rst is high so an interrupted instruction never writes.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   Op              opcode from the IR
//   mem_ready       memory completes the current access this cycle
//   PCWrite..illegal datapath enables, mux selects, En_UC class, illegal pulse
// Parameter:
//   RESET_STATE     state loaded on reset (default FETCH)
// Optional feature macro: MULTICYCLE_JUMP_EN (decode j and build JUMP state).
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] En_UC,
    output logic       illegal
);

    state_t    state;
    state_t    state_next;
    ctrl_out_t dec;
    ctrl_out_t gated;

    // NOTE: state register uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) state <= state_t'(RESET_STATE);
        else     state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:                      state_next = S_MEM_ADR;
                    OP_R:                              state_next = S_EXECUTE;
                    OP_BEQ:                            state_next = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_IMM_EX;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:                              state_next = S_JUMP;
`endif
                    default:                           state_next = S_FETCH;
                endcase
            end
            S_MEM_ADR: begin
                if (Op == OP_LW)      state_next = S_MEM_RD;
                else if (Op == OP_SW) state_next = S_MEM_WR;
                else                  state_next = S_FETCH;
            end
            S_MEM_RD:  state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:  state_next = S_FETCH;
            S_MEM_WR:  state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXECUTE: state_next = S_ALU_WB;
            S_ALU_WB:  state_next = S_FETCH;
            S_BRANCH:  state_next = S_FETCH;
            S_IMM_EX:  state_next = S_IMM_WB;
            S_IMM_WB:  state_next = S_FETCH;
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP:    state_next = S_FETCH;
`endif
            default:   state_next = S_FETCH;
        endcase
    end

    ctrl_out_decode u_decode (
        .state     (state),
        .Op        (Op),
        .mem_ready (mem_ready),
        .out       (dec)
    );

    // Reset gating acts combinationally so a write in flight is suppressed
    // in the very cycle reset is applied.
    assign gated = rst ? '0 : dec;

    assign PCWrite  = gated.pc_write;
    assign Branch   = gated.branch;
    assign IorD     = gated.i_or_d;
    assign MemRead  = gated.mem_read;
    assign MemWrite = gated.mem_write;
    assign IRWrite  = gated.ir_write;
    assign MemtoReg = gated.mem_to_reg;
    assign RegDst   = gated.reg_dst;
    assign RegWrite = gated.reg_write;
    assign ALUSrcA  = gated.alu_src_a;
    assign ALUSrcB  = gated.alu_src_b;
    assign PCSrc    = gated.pc_src;
    assign En_UC    = gated.en_uc;
    assign illegal  = gated.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each cycle the expected 18-bit
// control vector is pushed to a scoreboard queue as stimulus is driven and
// popped/compared against the DUT outputs at the following falling edge.
// Expected vectors are built from the per-state output table.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] En_UC;
    logic       illegal;

    int n_cmp = 0;
    int n_err = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .Op        (op),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .MemtoReg  (MemtoReg),
        .RegDst    (RegDst),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .PCSrc     (PCSrc),
        .En_UC     (En_UC),
        .illegal   (illegal)
    );

    // Vector order: PCWrite Branch IorD MemRead MemWrite IRWrite MemtoReg
    //               RegDst RegWrite ALUSrcA ALUSrcB[1:0] PCSrc[1:0] En_UC[2:0] illegal
    function automatic logic [17:0] mk(input logic pcw, input logic br, input logic iord,
                                       input logic mrd, input logic mwr, input logic irw,
                                       input logic m2r, input logic rdst, input logic rw,
                                       input logic srca, input logic [1:0] srcb,
                                       input logic [1:0] pcs, input logic [2:0] en,
                                       input logic ill);
        return {pcw, br, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcs, en, ill};
    endfunction

    function automatic logic [17:0] observed();
        return {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSrc, En_UC, illegal};
    endfunction

    //                                  pcw br iord mrd mwr irw m2r rdst rw srca srcb   pcs    en      ill
    localparam logic [17:0] V_ZERO     = 18'd0;
    localparam logic [17:0] V_FETCH    = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b001,1'b0};
    localparam logic [17:0] V_FETCH_WT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b001,1'b0};
    localparam logic [17:0] V_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b001,1'b0};
    localparam logic [17:0] V_DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b001,1'b1};
    localparam logic [17:0] V_MEM_ADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b001,1'b0};
    localparam logic [17:0] V_MEM_RD   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0};
    localparam logic [17:0] V_MEM_WB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0};
    localparam logic [17:0] V_MEM_WR   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0};
    localparam logic [17:0] V_EXECUTE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b000,1'b0};
    localparam logic [17:0] V_ALU_WB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0};
    localparam logic [17:0] V_BRANCH   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b010,1'b0};
    localparam logic [17:0] V_IMM_WB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0};
    localparam logic [17:0] V_JUMP     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b000,1'b0};

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    // One clock cycle: drive inputs, push expectation, compare at negedge.
    task automatic step(input string tag, input logic r, input logic mr, input logic [17:0] e);
        logic [17:0] want;
        rst       = r;
        mem_ready = mr;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, observed(), ~observed());
        end else begin
            want = exp_q.pop_front();
            check(tag, observed(), want);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] imm_class(input logic [5:0] o);
        case (o)
            6'b001100: return 3'b011;
            6'b001101: return 3'b100;
            6'b001010: return 3'b101;
            default:   return 3'b001;
        endcase
    endfunction

    // Runs one full instruction starting in FETCH. mem_ready is randomised
    // in states where it must be ignored.
    task automatic run_instr(input string name, input logic [5:0] o,
                             input int fetch_waits, input int mem_waits);
        logic [17:0] v_imm;
        op = o;
        for (int i = 0; i < fetch_waits; i++) step({name, "_fetch_wait"}, 1'b0, 1'b0, V_FETCH_WT);
        step({name, "_fetch"}, 1'b0, 1'b1, V_FETCH);
        case (o)
            6'b000000: begin
                step({name, "_decode"}, 1'b0, rb(), V_DECODE);
                step({name, "_execute"}, 1'b0, rb(), V_EXECUTE);
                step({name, "_alu_wb"}, 1'b0, rb(), V_ALU_WB);
            end
            6'b100011: begin
                step({name, "_decode"}, 1'b0, rb(), V_DECODE);
                step({name, "_mem_adr"}, 1'b0, rb(), V_MEM_ADR);
                for (int i = 0; i < mem_waits; i++) step({name, "_mem_rd_wait"}, 1'b0, 1'b0, V_MEM_RD);
                step({name, "_mem_rd"}, 1'b0, 1'b1, V_MEM_RD);
                step({name, "_mem_wb"}, 1'b0, rb(), V_MEM_WB);
            end
            6'b101011: begin
                step({name, "_decode"}, 1'b0, rb(), V_DECODE);
                step({name, "_mem_adr"}, 1'b0, rb(), V_MEM_ADR);
                for (int i = 0; i < mem_waits; i++) step({name, "_mem_wr_wait"}, 1'b0, 1'b0, V_MEM_WR);
                step({name, "_mem_wr"}, 1'b0, 1'b1, V_MEM_WR);
            end
            6'b000100: begin
                step({name, "_decode"}, 1'b0, rb(), V_DECODE);
                step({name, "_branch"}, 1'b0, rb(), V_BRANCH);
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                v_imm = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,imm_class(o),1'b0};
                step({name, "_decode"}, 1'b0, rb(), V_DECODE);
                step({name, "_imm_ex"}, 1'b0, rb(), v_imm);
                step({name, "_imm_wb"}, 1'b0, rb(), V_IMM_WB);
            end
`ifdef MULTICYCLE_JUMP_EN
            6'b000010: begin
                step({name, "_decode"}, 1'b0, rb(), V_DECODE);
                step({name, "_jump"}, 1'b0, rb(), V_JUMP);
            end
`endif
            default: begin
                step({name, "_decode_illegal"}, 1'b0, rb(), V_DEC_ILL);
            end
        endcase
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        op        = 6'b000000;
        @(posedge clk);
        #1;
        step("reset_hold_mr1", 1'b1, 1'b1, V_ZERO);
        step("reset_hold_mr0", 1'b1, 1'b0, V_ZERO);

        run_instr("r",     6'b000000, 0, 0);
        run_instr("lw",    6'b100011, 0, 2);
        run_instr("lw_fw", 6'b100011, 1, 0);
        run_instr("sw",    6'b101011, 0, 1);
        run_instr("beq",   6'b000100, 2, 0);
        run_instr("addi",  6'b001000, 0, 0);
        run_instr("andi",  6'b001100, 0, 0);
        run_instr("ori",   6'b001101, 0, 0);
        run_instr("slti",  6'b001010, 0, 0);
        run_instr("ill",   6'b111111, 0, 0);
        run_instr("j",     6'b000010, 0, 0);
        run_instr("r2",    6'b000000, 1, 0);

        // Reset during MEM_WR: MemWrite must drop that cycle, FETCH follows.
        op = 6'b101011;
        step("rst_sw_fetch",   1'b0, 1'b1, V_FETCH);
        step("rst_sw_decode",  1'b0, 1'b0, V_DECODE);
        step("rst_sw_mem_adr", 1'b0, 1'b0, V_MEM_ADR);
        step("rst_sw_mem_wr",  1'b0, 1'b0, V_MEM_WR);
        step("rst_sw_reset",   1'b1, 1'b0, V_ZERO);
        run_instr("after_rst_beq", 6'b000100, 0, 0);

        if (exp_q.size() != 0) check("queue_drained", 18'(exp_q.size()), 18'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
